// File: rtl/rgbtohsv_stream.sv
// rtl/rgbtohsv_stream.sv - fixed-point RGB to HSV converter with valid/ready handshakes
module rgbtohsv_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_g,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+2:0] out_h,
  output logic [W-1:0] out_s,
  output logic [W-1:0] out_v,
  output logic         out_gray
);
  localparam int CW           = $clog2(W + 2);
  localparam int SIX_SEXTANTS = 6 << W;

  typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;

  state_t         state_q;
  logic [W-1:0]   r_q, g_q, b_q;
  logic [W-1:0]   max_q, delta_q;
  logic           neg_q;
  logic [2:0]     base_q;
  logic [W:0]     hrem_q, srem_q;
  logic [W-1:0]   hquo_q, squo_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q, out_valid_q, out_gray_q;
  logic [W+2:0]   out_h_q;
  logic [W-1:0]   out_s_q, out_v_q;

  logic [W-1:0]   max_d, min_d, delta_d, num_abs_d;
  logic signed [W:0] num_d;
  logic           neg_d;
  logic [2:0]     base_d;

  logic           h_ge, s_ge;
  logic [W-1:0]   h_sub, s_sub;
  logic [W:0]     hquo_d, squo_d;
  logic [W+3:0]   h_base, h_q, h_sum;
  logic [W+2:0]   h_res;
  logic [W-1:0]   s_res;
  logic           gray_d;

  // Pick the max channel (ties favour R, then G), signed hue numerator and sextant base
  always_comb begin
    max_d  = r_q;
    num_d  = '0;
    base_d = 3'd0;
    if (r_q >= g_q && r_q >= b_q) begin
      max_d  = r_q;
      num_d  = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
      base_d = 3'd0;
    end else if (g_q >= b_q) begin
      max_d  = g_q;
      num_d  = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
      base_d = 3'd2;
    end else begin
      max_d  = b_q;
      num_d  = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
      base_d = 3'd4;
    end
    min_d = r_q;
    if (g_q < min_d) min_d = g_q;
    if (b_q < min_d) min_d = b_q;
    delta_d   = max_d - min_d;
    neg_d     = num_d[W];
    num_abs_d = neg_d ? W'(-num_d) : W'(num_d);
  end

  // One restoring step per divider; a zero divisor just yields all-ones, masked by the gray flag
  always_comb begin
    h_ge   = hrem_q >= {1'b0, delta_q};
    h_sub  = h_ge ? W'(hrem_q - {1'b0, delta_q}) : hrem_q[W-1:0];
    hquo_d = {hquo_q, h_ge};
    s_ge   = srem_q >= {1'b0, max_q};
    s_sub  = s_ge ? W'(srem_q - {1'b0, max_q}) : srem_q[W-1:0];
    squo_d = {squo_q, s_ge};
  end

  // Final hue assembly with wrap into 0..6*2^W-1, and saturation clamp
  always_comb begin
    h_base = {1'b0, base_q, {W{1'b0}}};
    h_q    = {3'b000, hquo_d};
    h_sum  = neg_q ? (h_base - h_q) : (h_base + h_q);
    h_res  = h_sum[W+3] ? (W+3)'(h_sum + (W+4)'(SIX_SEXTANTS)) : h_sum[W+2:0];
    s_res  = squo_d[W] ? {W{1'b1}} : squo_d[W-1:0];
    gray_d = (delta_q == '0);
  end

  // Control FSM with registered handshakes and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      max_q       <= '0;
      delta_q     <= '0;
      neg_q       <= 1'b0;
      base_q      <= '0;
      hrem_q      <= '0;
      srem_q      <= '0;
      hquo_q      <= '0;
      squo_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_gray_q  <= 1'b0;
      out_h_q     <= '0;
      out_s_q     <= '0;
      out_v_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            r_q        <= in_r;
            g_q        <= in_g;
            b_q        <= in_b;
            in_ready_q <= 1'b0;
            state_q    <= PREP;
          end
        end
        PREP: begin
          max_q   <= max_d;
          delta_q <= delta_d;
          neg_q   <= neg_d;
          base_q  <= base_d;
          hrem_q  <= {1'b0, num_abs_d};
          srem_q  <= {1'b0, delta_d};
          hquo_q  <= '0;
          squo_q  <= '0;
          cnt_q   <= CW'(W + 1);
          state_q <= DIV;
        end
        DIV: begin
          hrem_q <= {h_sub, 1'b0};
          srem_q <= {s_sub, 1'b0};
          hquo_q <= hquo_d[W-1:0];
          squo_q <= squo_d[W-1:0];
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            out_h_q     <= gray_d ? '0 : h_res;
            out_s_q     <= gray_d ? '0 : s_res;
            out_v_q     <= max_q;
            out_gray_q  <= gray_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_h     = out_h_q;
  assign out_s     = out_s_q;
  assign out_v     = out_v_q;
  assign out_gray  = out_gray_q;
endmodule

// File: tb/tb_rgbtohsv_stream.sv
// tb/tb_rgbtohsv_stream.sv - self-checking bench for rgbtohsv_stream
module tb_rgbtohsv_stream;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_r = '0, in_g = '0, in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W+2:0] out_h;
  logic [W-1:0] out_s, out_v;
  logic         out_gray;

  rgbtohsv_stream #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_gray(out_gray)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: HSV from the channel values with plain integer arithmetic
  function automatic void model(input int r, input int g, input int b,
                                output int h, output int s, output int v, output int gy);
    int mx, mn, d, num, base, q;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    v = mx;
    gy = (d == 0) ? 1 : 0;
    h = 0;
    s = 0;
    if (d != 0) begin
      if (r == mx) begin num = g - b; base = 0; end
      else if (g == mx) begin num = b - r; base = 2; end
      else begin num = r - g; base = 4; end
      q = ((num < 0 ? -num : num) * (1 << W)) / d;
      h = base * (1 << W) + (num < 0 ? -q : q);
      if (h < 0) h += 6 * (1 << W);
      s = (d * (1 << W)) / mx;
      if (s > (1 << W) - 1) s = (1 << W) - 1;
    end
  endfunction

  typedef struct {int h; int s; int v; int g; int acc;} exp_t;
  exp_t sb[$];
  int   last_acc = -1;
  bit   stream_mode = 1'b0;
  bit   prev_ov = 1'b0;

  // Scoreboard monitor: push on accept, compare every cycle out_valid is high
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      check("ready_valid_exclusive", int'(in_ready && out_valid), 0);
      if (in_valid && in_ready) begin
        model(int'(in_r), int'(in_g), int'(in_b), e.h, e.s, e.v, e.g);
        e.acc = cyc + 1;
        if (stream_mode && last_acc >= 0) check("accept_spacing", e.acc - last_acc, W + 4);
        last_acc = e.acc;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb[0];
          check("model_h", int'(out_h), e.h);
          check("model_s", int'(out_s), e.s);
          check("model_v", int'(out_v), e.v);
          check("model_gray", int'(out_gray), e.g);
          if (!prev_ov) check("latency", cyc - e.acc, W + 2);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int r, input int g, input int b);
    bit ok = 1'b0;
    int n = 0;
    @(posedge clk); #1;
    in_r = W'(r); in_g = W'(g); in_b = W'(b);
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = out_valid;
      n++;
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (out_valid) check("drain_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input int r, input int g, input int b,
                          input int eh, input int es, input int ev, input int eg);
    bit ok;
    send(r, g, b);
    wait_out(ok);
    if (ok) begin
      check({name, "_h"}, int'(out_h), eh);
      check({name, "_s"}, int'(out_s), es);
      check({name, "_v"}, int'(out_v), ev);
      check({name, "_gray"}, int'(out_gray), eg);
    end
    @(negedge clk);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mh, ms, mv, mg, acc_cnt, guard, ce;
    bit ok;

    // Model pinned against hand-computed values
    model(10, 20, 30, mh, ms, mv, mg);
    check("pin_model_h", mh, 896);
    check("pin_model_s", ms, 170);
    model(255, 0, 255, mh, ms, mv, mg);
    check("pin_model_wrap_h", mh, 1280);

    // Reset state
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_h", int'(out_h), 0);
    check("rst_out_s", int'(out_s), 0);
    check("rst_out_v", int'(out_v), 0);
    check("rst_out_gray", int'(out_gray), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed pixels
    directed("red",    255,   0,   0,    0, 255, 255, 0);
    directed("green",    0, 255,   0,  512, 255, 255, 0);
    directed("blue",     0,   0, 255, 1024, 255, 255, 0);
    directed("magenta",255,   0, 255, 1280, 255, 255, 0);
    directed("yellow", 255, 255,   0,  256, 255, 255, 0);
    directed("generic",200, 100,  50,   85, 192, 200, 0);
    directed("gray",   128, 128, 128,    0,   0, 128, 1);
    directed("black",    0,   0,   0,    0,   0,   0, 1);

    // Streaming with in_valid held high
    stream_mode = 1'b1;
    last_acc = -1;
    acc_cnt = 0;
    guard = 0;
    @(posedge clk); #1;
    in_r = W'($urandom_range(0, 255));
    in_g = W'($urandom_range(0, 255));
    in_b = W'($urandom_range(0, 255));
    in_valid = 1'b1;
    while (acc_cnt < 20 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        acc_cnt++;
        @(posedge clk); #1;
        in_r = W'($urandom_range(0, 255));
        in_g = ($urandom_range(0, 3) == 0) ? in_r : W'($urandom_range(0, 255));
        in_b = W'($urandom_range(0, 255));
        if (acc_cnt == 20) in_valid = 1'b0;
      end
    end
    check("stream_accepts", acc_cnt, 20);
    in_valid = 1'b0;
    wait_out(ok);
    @(negedge clk);
    wait_drain();
    stream_mode = 1'b0;

    // Backpressure with a pixel waiting at the input
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(200, 100, 50);
    wait_out(ok);
    @(posedge clk); #1;
    in_r = 8'd0; in_g = 8'd255; in_b = 8'd0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_hold_h", int'(out_h), 85);
      check("bp_hold_s", int'(out_s), 192);
      check("bp_pending", sb.size(), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    ce = cyc + 1;
    check("bp_release_valid", int'(out_valid), 1);
    @(negedge clk);
    check("bp_accept_next_cycle", int'(in_ready), 1);
    check("bp_accept_edge", cyc + 1 - ce, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(ok);
    @(negedge clk);
    wait_drain();

    // Asynchronous reset in the middle of the divide
    send(255, 0, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_h", int'(out_h), 0);
    check("midrst_out_s", int'(out_s), 0);
    check("midrst_out_v", int'(out_v), 0);
    check("midrst_out_gray", int'(out_gray), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", int'(in_ready), 1);
    directed("after_reset", 10, 20, 30, 896, 170, 30, 0);

    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
